// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debouncer slice.
package debounce_pkg;

   localparam int GLITCH_W = 8;

   function automatic int cnt_width(input int stable);
      return $clog2(stable + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter, clean level and busy flag.
// Optional rejected-bounce counter enabled by DEBOUNCE_GLITCH_CNT_EN.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                entrada,
   output logic                saida,
   output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   localparam int              CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // NOTE: every flop here, the synchroniser chain included, is reset and updated with
   // non-blocking assignments so that all channel state advances on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], entrada};
      end
   end

   // Any sample matching the current level restarts the count, so only an
   // uninterrupted run of STABLE_CYCLES differing samples is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         saida <= RESET_LEVEL;
      end else if (s == saida) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         saida <= s;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign busy = (cnt != '0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_cnt <= '0;
      end else if ((s == saida) && (cnt != '0) && (glitch_cnt != '1)) begin
         glitch_cnt <= glitch_cnt + GLITCH_W'(1);
      end
   end
`endif

endmodule

// File: rtl/debouncer_sync.sv
// Multi-channel input debouncer feeding the edge detector; channels are independent.
// Optional per-channel glitch counters enabled by DEBOUNCE_GLITCH_CNT_EN.
module debouncer_sync
   import debounce_pkg::*;
#(
   parameter int N_CH          = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CH-1:0]            entrada,
   output logic [N_CH-1:0]            saida,
   output logic [N_CH-1:0]            busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [N_CH*GLITCH_W-1:0]   glitch_cnt
`endif
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES),
         .RESET_LEVEL   (RESET_LEVEL)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .entrada    (entrada[i]),
         .saida      (saida[i]),
         .busy       (busy[i])
`ifdef DEBOUNCE_GLITCH_CNT_EN
         ,
         .glitch_cnt (glitch_cnt[GLITCH_W*i +: GLITCH_W])
`endif
      );
   end

endmodule

// File: tb/tb_debouncer_sync.sv
// Directed self-checking bench for debouncer_sync (default and STABLE_CYCLES=1 builds).
module tb_debouncer_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  entrada;
   logic [1:0]  saida;
   logic [1:0]  busy;
   logic [0:0]  entrada1;
   logic [0:0]  saida1;
   logic [0:0]  busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [15:0] glitch_cnt;
   logic [7:0]  glitch_cnt1;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Per-edge expectations (index = edge number after the step) for the bounce cases.
   logic [1:0] t3_busy  [1:9] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
   logic [1:0] t5_saida [1:9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
   logic [1:0] t5_busy  [1:9] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};

   always #5 clk = ~clk;

   debouncer_sync dut (
      .clk        (clk),
      .rst        (rst),
      .entrada    (entrada),
      .saida      (saida),
      .busy       (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt)
`endif
   );

   debouncer_sync #(.N_CH(1), .STABLE_CYCLES(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .entrada    (entrada1),
      .saida      (saida1),
      .busy       (busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt1)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      entrada = 2'b00;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      entrada  = 2'b00;
      entrada1 = 1'b0;
      repeat (2) tick();
      check("rst_saida", 16'(saida), 16'h0);
      check("rst_busy", 16'(busy), 16'h0);
      rst = 1'b0;

      // 1: asynchronous reset in the middle of a pending candidate
      entrada = 2'b11;
      repeat (4) tick();
      check("t1_busy_pending", 16'(busy), 16'h3);
      #2 rst = 1'b1;
      #1;
      check("t1_async_saida", 16'(saida), 16'h0);
      check("t1_async_busy", 16'(busy), 16'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("t1_glitch", glitch_cnt, 16'h0);
`endif
      repeat (2) tick();
      check("t1_held_saida", 16'(saida), 16'h0);
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("t1_saida_e%0d", e), 16'(saida), (e == 6) ? 16'h3 : 16'h0);
         check($sformatf("t1_busy_e%0d", e), 16'(busy), (e >= 3 && e <= 5) ? 16'h3 : 16'h0);
      end

      // 2: clean step on channel 0
      do_reset();
      entrada = 2'b01;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("t2_saida_e%0d", e), 16'(saida), (e == 6) ? 16'h1 : 16'h0);
         check($sformatf("t2_busy_e%0d", e), 16'(busy), (e >= 3 && e <= 5) ? 16'h1 : 16'h0);
      end
      repeat (3) tick();
      check("t2_saida_hold", 16'(saida), 16'h1);

      // 3: bounce on channel 0 (high 2 clk, low 1 clk, then high)
      do_reset();
      entrada = 2'b01;
      for (int e = 1; e <= 9; e++) begin
         tick();
         check($sformatf("t3_saida_e%0d", e), 16'(saida), (e == 9) ? 16'h1 : 16'h0);
         check($sformatf("t3_busy_e%0d", e), 16'(busy), 16'(t3_busy[e]));
         if (e == 2) entrada = 2'b00;
         if (e == 3) entrada = 2'b01;
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("t3_glitch", glitch_cnt, 16'h0001);
`endif

      // 4: release and a 3-clock pulse that must be rejected
      entrada = 2'b11;
      repeat (6) tick();
      check("t4_saida_11", 16'(saida), 16'h3);
      entrada = 2'b10;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("t4_rel_e%0d", e), 16'(saida), (e == 6) ? 16'h2 : 16'h3);
      end
      entrada = 2'b00;
      for (int e = 1; e <= 10; e++) begin
         tick();
         check($sformatf("t4_pulse_saida_e%0d", e), 16'(saida), 16'h2);
         check($sformatf("t4_pulse_busy_e%0d", e), 16'(busy), (e >= 3 && e <= 5) ? 16'h2 : 16'h0);
         if (e == 3) entrada = 2'b10;
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("t4_glitch", glitch_cnt, 16'h0101);
`endif

      // 5: both channels step together, channel 1 bounces once
      do_reset();
      entrada = 2'b11;
      for (int e = 1; e <= 9; e++) begin
         tick();
         check($sformatf("t5_saida_e%0d", e), 16'(saida), 16'(t5_saida[e]));
         check($sformatf("t5_busy_e%0d", e), 16'(busy), 16'(t5_busy[e]));
         if (e == 2) entrada = 2'b01;
         if (e == 3) entrada = 2'b11;
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("t5_glitch", glitch_cnt, 16'h0100);
`endif

      // 6: 300 single-clock bounces on channel 0
      do_reset();
      repeat (300) begin
         entrada = 2'b01;
         tick();
         entrada = 2'b00;
         tick();
      end
      repeat (4) tick();
      check("t6_saida", 16'(saida), 16'h0);
      check("t6_busy", 16'(busy), 16'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("t6_glitch_sat", glitch_cnt, 16'h00FF);
`endif

      // STABLE_CYCLES=1 instance: level follows the sync output one edge later
      rst      = 1'b1;
      entrada1 = 1'b0;
      tick();
      rst      = 1'b0;
      entrada1 = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check($sformatf("p1_rise_e%0d", e), 16'(saida1), (e == 3) ? 16'h1 : 16'h0);
         check($sformatf("p1_busy_e%0d", e), 16'(busy1), 16'h0);
      end
      entrada1 = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check($sformatf("p1_fall_e%0d", e), 16'(saida1), (e == 3) ? 16'h0 : 16'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
